// File: rtl/ti_share_refresh_reg.sv
// Register/refresh stage between TI S-box rounds: optional ring remask of the
// shared nibble, 2-entry elastic buffer, flop-driven share output.
module ti_share_refresh_reg #(
  parameter int NS      = 2,
  parameter int REFRESH = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NS-1:0]   in_shares,
  input  logic              rnd_valid,
  input  logic [4*NS-1:0]   rnd_in,
  output logic              rnd_ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NS-1:0]   out_shares,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam int W = 4 * NS;

  logic [1:0]   count;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [W-1:0] masked;
  logic         rnd_ok;
  logic         accept;
  logic         pop;

  generate
    if (REFRESH != 0) begin : g_refresh
      // Each mask share is used by two neighbours, so the XOR of all shares is unchanged.
      for (genvar i = 0; i < NS; i++) begin : g_share
        assign masked[4*i +: 4] = in_shares[4*i +: 4]
                                ^ rnd_in[4*i +: 4]
                                ^ rnd_in[4*((i + 1) % NS) +: 4];
      end
      assign rnd_ok = rnd_valid;
    end else begin : g_plain
      logic unused_rnd;
      assign unused_rnd = ^{rnd_valid, rnd_in};
      assign masked     = in_shares;
      assign rnd_ok     = 1'b1;
    end
  endgenerate

  // Handshakes come from registered occupancy only; rst gates them low immediately.
  assign in_ready   = !rst && (count < 2'd2);
  assign out_valid  = !rst && (count != 2'd0);
  assign accept     = in_valid && in_ready && rnd_ok;
  assign pop        = out_valid && out_ready;
  assign rnd_ack    = accept && (REFRESH != 0);
  assign out_shares = head_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 2'd0;
      head_q   <= '0;
      tail_q   <= '0;
      beat_cnt <= '0;
    end else begin
      if (accept) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      case (count)
        2'd0: begin
          if (accept) begin
            head_q <= masked;
            count  <= 2'd1;
          end
        end
        2'd1: begin
          if (accept && pop) begin
            head_q <= masked;
          end else if (accept) begin
            tail_q <= masked;
            count  <= 2'd2;
          end else if (pop) begin
            count  <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_q <= tail_q;
            count  <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ti_share_refresh_reg.sv
// Directed bench: a plain-register instance (p_) and a refreshing instance
// with a 4-bit beat counter (r_), sharing clock and reset.
module tb_ti_share_refresh_reg;

  logic clk;
  logic rst;

  logic       p_in_valid, p_in_ready, p_rnd_valid, p_rnd_ack, p_out_valid, p_out_ready;
  logic [7:0] p_in_shares, p_rnd_in, p_out_shares;
  logic [15:0] p_beat_cnt;

  logic       r_in_valid, r_in_ready, r_rnd_valid, r_rnd_ack, r_out_valid, r_out_ready;
  logic [7:0] r_in_shares, r_rnd_in, r_out_shares;
  logic [3:0] r_beat_cnt;

  int passed = 0;
  int total  = 0;

  ti_share_refresh_reg #(.NS(2), .REFRESH(0), .CNT_W(16)) u_plain (
    .clk(clk), .rst(rst),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_shares(p_in_shares),
    .rnd_valid(p_rnd_valid), .rnd_in(p_rnd_in), .rnd_ack(p_rnd_ack),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_shares(p_out_shares),
    .beat_cnt(p_beat_cnt)
  );

  ti_share_refresh_reg #(.NS(2), .REFRESH(1), .CNT_W(4)) u_ref (
    .clk(clk), .rst(rst),
    .in_valid(r_in_valid), .in_ready(r_in_ready), .in_shares(r_in_shares),
    .rnd_valid(r_rnd_valid), .rnd_in(r_rnd_in), .rnd_ack(r_rnd_ack),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_shares(r_out_shares),
    .beat_cnt(r_beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    p_in_valid = 0; p_in_shares = 8'h00; p_rnd_valid = 0; p_rnd_in = 8'h00; p_out_ready = 0;
    r_in_valid = 0; r_in_shares = 8'h00; r_rnd_valid = 0; r_rnd_in = 8'h00; r_out_ready = 0;
    #2;
    chk("rst_r_in_ready", r_in_ready, 0);
    chk("rst_r_out_valid", r_out_valid, 0);
    chk("rst_r_out_shares", r_out_shares, 8'h00);
    chk("rst_r_beat_cnt", r_beat_cnt, 0);
    chk("rst_p_in_ready", p_in_ready, 0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("post_rst_p_in_ready", p_in_ready, 1);
    chk("post_rst_r_in_ready", r_in_ready, 1);

    // 1: plain register, randomness ignored
    p_in_valid = 1; p_in_shares = 8'h5A; p_out_ready = 1; p_rnd_valid = 1; p_rnd_in = 8'hFF;
    #1;
    chk("t1_rnd_ack_acc", p_rnd_ack, 0);
    step();
    p_in_valid = 0;
    #1;
    chk("t1_out_valid", p_out_valid, 1);
    chk("t1_out_shares", p_out_shares, 8'h5A);
    chk("t1_beat_cnt", p_beat_cnt, 1);
    chk("t1_rnd_ack", p_rnd_ack, 0);
    step();
    chk("t1_drained", p_out_valid, 0);
    chk("t1_hold_shares", p_out_shares, 8'h5A);

    // 2: remask 3C with 96 -> C3
    r_in_valid = 1; r_in_shares = 8'h3C; r_rnd_valid = 1; r_rnd_in = 8'h96; r_out_ready = 1;
    #1;
    chk("t2_rnd_ack_hi", r_rnd_ack, 1);
    step();
    r_in_valid = 0; r_rnd_valid = 0;
    #1;
    chk("t2_rnd_ack_lo", r_rnd_ack, 0);
    chk("t2_out_valid", r_out_valid, 1);
    chk("t2_out_shares", r_out_shares, 8'hC3);
    chk("t2_unmasked", r_out_shares[7:4] ^ r_out_shares[3:0], 4'hF);
    chk("t2_beat_cnt", r_beat_cnt, 1);
    step();
    chk("t2_drained", r_out_valid, 0);

    // 3: backpressure on plain instance
    p_out_ready = 0; p_in_valid = 1; p_in_shares = 8'h11;
    step();
    chk("t3_first_out", p_out_shares, 8'h11);
    chk("t3_ready_after1", p_in_ready, 1);
    p_in_shares = 8'h22;
    step();
    chk("t3_ready_after2", p_in_ready, 0);
    p_in_shares = 8'h33;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_stall_ready", p_in_ready, 0);
      chk("t3_stall_valid", p_out_valid, 1);
      chk("t3_stall_shares", p_out_shares, 8'h11);
    end
    chk("t3_stall_beats", p_beat_cnt, 3);
    p_out_ready = 1;
    step();
    chk("t3_second_out", p_out_shares, 8'h22);
    chk("t3_second_valid", p_out_valid, 1);
    step();
    p_in_valid = 0;
    #1;
    chk("t3_third_out", p_out_shares, 8'h33);
    chk("t3_third_valid", p_out_valid, 1);
    chk("t3_beats", p_beat_cnt, 4);
    step();
    chk("t3_drained", p_out_valid, 0);

    // 4: randomness starvation
    r_out_ready = 0; r_in_valid = 1; r_in_shares = 8'hA5; r_rnd_valid = 0; r_rnd_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_starve_ack", r_rnd_ack, 0);
      step();
      chk("t4_starve_valid", r_out_valid, 0);
    end
    chk("t4_starve_beats", r_beat_cnt, 1);
    r_rnd_valid = 1;
    #1;
    chk("t4_ack", r_rnd_ack, 1);
    step();
    r_in_valid = 0; r_rnd_valid = 0;
    #1;
    chk("t4_beats", r_beat_cnt, 2);
    chk("t4_out_valid", r_out_valid, 1);
    chk("t4_out_shares", r_out_shares, 8'hA5);
    r_out_ready = 1;
    step();
    chk("t4_drained", r_out_valid, 0);

    // 5: streaming, accept and pop every cycle
    p_out_ready = 1; p_in_valid = 1; p_in_shares = 8'h40;
    step();
    for (int k = 1; k < 10; k++) begin
      p_in_shares = 8'h40 + 8'(k);
      #1;
      chk("t5_in_ready", p_in_ready, 1);
      step();
      chk("t5_out_valid", p_out_valid, 1);
      chk("t5_out_shares", p_out_shares, 8'h40 + 8'(k));
    end
    p_in_valid = 0;
    step();
    chk("t5_drained", p_out_valid, 0);
    chk("t5_beats", p_beat_cnt, 14);

    // 6: counter wrap, then reset while full at beat_cnt=15
    r_out_ready = 1; r_rnd_valid = 1; r_rnd_in = 8'h00; r_in_shares = 8'h69; r_in_valid = 1;
    repeat (13) step();
    r_in_valid = 0;
    #1;
    chk("t6_at15", r_beat_cnt, 15);
    r_in_valid = 1;
    step();
    r_in_valid = 0;
    #1;
    chk("t6_wrap", r_beat_cnt, 0);
    step();
    r_in_valid = 1;
    repeat (14) step();
    r_out_ready = 0;
    step();
    r_in_valid = 0;
    #1;
    chk("t6_full_beats", r_beat_cnt, 15);
    chk("t6_full_ready", r_in_ready, 0);
    #1;
    rst = 1;
    #1;
    chk("t6_rst_out_valid", r_out_valid, 0);
    chk("t6_rst_out_shares", r_out_shares, 8'h00);
    chk("t6_rst_beats", r_beat_cnt, 0);
    chk("t6_rst_in_ready", r_in_ready, 0);
    step();
    rst = 0;
    r_in_valid = 1; r_in_shares = 8'h7E; r_out_ready = 1;
    step();
    r_in_valid = 0;
    #1;
    chk("t6_resume_shares", r_out_shares, 8'h7E);
    chk("t6_resume_beats", r_beat_cnt, 1);
    step();
    chk("t6_resume_drained", r_out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
